neuron_forward: RTL and testbench



---
 rtl/neuron_pkg.sv | 26 ++
 rtl/sigmoid_plan.sv | 30 +++
 rtl/neuron_forward.sv | 108 ++++++++++
 tb/tb_neuron_forward.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared fixed-point types, PLAN sigmoid constants and FSM states
// for the neuron forward-pass blocks.
package neuron_pkg;

    localparam int FRAC_BITS = 12;
    localparam int FIX_ONE   = 4096;

    typedef logic signed [15:0] fix_t;

    // PLAN breakpoints on |s|, Q4.12
    localparam logic [16:0] BP_SAT = 17'd20480;
    localparam logic [16:0] BP_HI  = 17'd9728;
    localparam logic [16:0] BP_MID = 17'd4096;

    localparam logic [15:0] OFS_HI  = 16'd3456;
    localparam logic [15:0] OFS_MID = 16'd2560;
    localparam logic [15:0] OFS_LO  = 16'd2048;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ACTIVATE,
        S_OUTPUT
    } nf_state_e;

endpackage

// File: rtl/sigmoid_plan.sv
// Combinational piecewise-linear (PLAN) sigmoid, Q4.12 in, 0..4096 out.
// Reusable by any neuron block needing the same activation.
module sigmoid_plan
    import neuron_pkg::*;
(
    input  logic signed [15:0] s,
    output logic signed [15:0] axon
);

    logic [16:0] ext;
    logic [16:0] a;
    logic [15:0] y;

    always_comb begin
        ext = {s[15], s};
        // 17-bit magnitude so that |-32768| is representable
        a = s[15] ? (17'd0 - ext) : ext;
        if (a >= BP_SAT) begin
            y = 16'(FIX_ONE);
        end else if (a >= BP_HI) begin
            y = 16'(a >> 5) + OFS_HI;
        end else if (a >= BP_MID) begin
            y = 16'(a >> 3) + OFS_MID;
        end else begin
            y = 16'(a >> 2) + OFS_LO;
        end
        axon = s[15] ? signed'(16'(FIX_ONE) - y) : signed'(y);
    end

endmodule

// File: rtl/neuron_forward.sv
// Forward-pass neuron: bias + sum(x*w) MAC, saturation to Q4.12,
// PLAN sigmoid, registered result on a valid/ready output port.
module neuron_forward
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DW       = 16,
    parameter int ACC_W    = 40
) (
    input  logic                 nf_clk,
    input  logic                 nf_rst_n,
    input  logic                 nf_start,
    input  logic signed [DW-1:0] nf_bias,
    output logic                 nf_busy,
    input  logic                 nf_in_valid,
    output logic                 nf_in_ready,
    input  logic signed [DW-1:0] nf_in_x,
    input  logic signed [DW-1:0] nf_in_w,
    output logic                 nf_out_valid,
    input  logic                 nf_out_ready,
    output logic signed [DW-1:0] nf_axon,
    output logic signed [DW-1:0] nf_sum
);

    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SUM_MIN = ACC_W'(-32768);

    nf_state_e state;
    nf_state_e state_next;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_add;
    logic signed [ACC_W-1:0] shifted;
    logic signed [2*DW-1:0]  prod;
    logic signed [DW-1:0]    sat;
    logic signed [DW-1:0]    plan_y;
    logic [CW-1:0]           cnt;
    logic                    take;

    assign nf_in_ready  = (state == S_ACCUM);
    assign nf_busy      = (state != S_IDLE);
    assign nf_out_valid = (state == S_OUTPUT);
    assign take         = nf_in_valid && nf_in_ready;

    always_comb begin
        prod    = nf_in_x * nf_in_w;
        acc_add = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        shifted = acc >>> FRAC_BITS;
        if (shifted > SUM_MAX) begin
            sat = 16'sh7fff;
        end else if (shifted < SUM_MIN) begin
            sat = 16'sh8000;
        end else begin
            sat = shifted[DW-1:0];
        end
    end

    sigmoid_plan u_plan (
        .s    (sat),
        .axon (plan_y)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:     if (nf_start) state_next = S_ACCUM;
            S_ACCUM:    if (take && cnt == LAST) state_next = S_ACTIVATE;
            S_ACTIVATE: state_next = S_OUTPUT;
            S_OUTPUT:   if (nf_out_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge nf_clk) begin
        if (!nf_rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            nf_sum  <= '0;
            nf_axon <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: begin
                    if (nf_start) begin
                        acc <= {{(ACC_W-DW-FRAC_BITS){nf_bias[DW-1]}},
                                nf_bias, {FRAC_BITS{1'b0}}};
                        cnt <= '0;
                    end
                end
                S_ACCUM: begin
                    if (take) begin
                        acc <= acc_add;
                        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                    end
                end
                S_ACTIVATE: begin
                    nf_sum  <= sat;
                    nf_axon <= plan_y;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_forward.sv
// Directed self-checking bench for neuron_forward and sigmoid_plan.
// Expected values are hand-computed Q4.12 results.
module tb_neuron_forward;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [15:0] bias = '0;
    logic signed [15:0] x = '0;
    logic signed [15:0] w = '0;
    logic busy;
    logic in_ready;
    logic out_valid;
    logic signed [15:0] axon;
    logic signed [15:0] sum;

    logic signed [15:0] sp_s = '0;
    logic signed [15:0] sp_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_forward dut (
        .nf_clk       (clk),
        .nf_rst_n     (rst_n),
        .nf_start     (start),
        .nf_bias      (bias),
        .nf_busy      (busy),
        .nf_in_valid  (in_valid),
        .nf_in_ready  (in_ready),
        .nf_in_x      (x),
        .nf_in_w      (w),
        .nf_out_valid (out_valid),
        .nf_out_ready (out_ready),
        .nf_axon      (axon),
        .nf_sum       (sum)
    );

    sigmoid_plan u_sp (
        .s    (sp_s),
        .axon (sp_y)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_eval(input int b, input int xs[4], input int ws[4],
                            output int s_o, output int a_o, output int lat);
        bias = 16'(b);
        start = 1'b1;
        cyc();
        start = 1'b0;
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            x = 16'(xs[i]);
            w = 16'(ws[i]);
            in_valid = 1'b1;
            cyc();
            lat++;
        end
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            cyc();
            lat++;
        end
        s_o = int'(sum);
        a_o = int'(axon);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks += 5;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        if (axon !== 16'sd0) begin
            errors++;
            $display("FAIL reset_axon got %0d want 0", axon);
        end
        if (sum !== 16'sd0) begin
            errors++;
            $display("FAIL reset_sum got %0d want 0", sum);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int s_o, a_o, lat;
        run_eval(0, '{4096, 2048, 0, 0}, '{2048, 2048, 0, 0}, s_o, a_o, lat);
        checks += 4;
        if (s_o != 3072) begin
            errors++;
            $display("FAIL basic_sum got %0d want 3072", s_o);
        end
        if (a_o != 2816) begin
            errors++;
            $display("FAIL basic_axon got %0d want 2816", a_o);
        end
        if (lat != 6) begin
            errors++;
            $display("FAIL basic_latency got %0d want 6", lat);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after got busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero();
        int s_o, a_o, lat;
        run_eval(0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, s_o, a_o, lat);
        checks += 2;
        if (s_o != 0) begin
            errors++;
            $display("FAIL zero_sum got %0d want 0", s_o);
        end
        if (a_o != 2048) begin
            errors++;
            $display("FAIL zero_axon got %0d want 2048", a_o);
        end
        run_eval(-4096, '{0, 0, 0, 0}, '{0, 0, 0, 0}, s_o, a_o, lat);
        checks += 2;
        if (s_o != -4096) begin
            errors++;
            $display("FAIL negbias_sum got %0d want -4096", s_o);
        end
        if (a_o != 1024) begin
            errors++;
            $display("FAIL negbias_axon got %0d want 1024", a_o);
        end
    endtask

    task automatic test_saturate();
        int s_o, a_o, lat;
        run_eval(28672, '{28672, 28672, 28672, 28672},
                 '{28672, 28672, 28672, 28672}, s_o, a_o, lat);
        checks += 2;
        if (s_o != 32767) begin
            errors++;
            $display("FAIL satpos_sum got %0d want 32767", s_o);
        end
        if (a_o != 4096) begin
            errors++;
            $display("FAIL satpos_axon got %0d want 4096", a_o);
        end
        run_eval(28672, '{28672, 28672, 28672, 28672},
                 '{-28672, -28672, -28672, -28672}, s_o, a_o, lat);
        checks += 2;
        if (s_o != -32768) begin
            errors++;
            $display("FAIL satneg_sum got %0d want -32768", s_o);
        end
        if (a_o != 0) begin
            errors++;
            $display("FAIL satneg_axon got %0d want 0", a_o);
        end
    endtask

    task automatic test_stall();
        int xs[4] = '{4096, 2048, 0, 0};
        int ws[4] = '{2048, 2048, 0, 0};
        int lat;
        int bad;
        bias = 16'sd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 6 && $urandom_range(0, 1) == 0; k++) begin
                in_valid = 1'b0;
                x = 16'sd1000;
                w = 16'sd1000;
                bias = 16'sd999;
                start = 1'b1;
                cyc();
            end
            start = 1'b0;
            x = 16'(xs[i]);
            w = 16'(ws[i]);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            cyc();
            lat++;
        end
        checks += 3;
        if (sum !== 16'sd3072) begin
            errors++;
            $display("FAIL stall_sum got %0d want 3072", sum);
        end
        if (axon !== 16'sd2816) begin
            errors++;
            $display("FAIL stall_axon got %0d want 2816", axon);
        end
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_in_output got %b want 0", in_ready);
        end
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            cyc();
            if (axon !== 16'sd2816 || out_valid !== 1'b1) bad++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int s_o, a_o, lat;
        bias = 16'sd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = 16'sd4096;
            w = (i == 0) ? 16'sd4096 : 16'sd0;
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 1'b1 || sum !== 16'sd4096 || axon !== 16'sd3072) begin
            errors++;
            $display("FAIL b2b_first got v=%b sum=%0d axon=%0d want 1/4096/3072",
                     out_valid, sum, axon);
        end
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_ignored got busy=%b want 0", busy);
        end
        run_eval(0, '{4096, 2048, 0, 0}, '{2048, 2048, 0, 0}, s_o, a_o, lat);
        checks++;
        if (s_o != 3072 || a_o != 2816 || lat != 6) begin
            errors++;
            $display("FAIL b2b_second got %0d/%0d/%0d want 3072/2816/6",
                     s_o, a_o, lat);
        end
    endtask

    task automatic test_reset_mid();
        int s_o, a_o, lat;
        bias = 16'sd4096;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x = 16'sd4096;
            w = 16'sd4096;
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        checks += 2;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl got busy=%b rdy=%b vld=%b want 0/0/0",
                     busy, in_ready, out_valid);
        end
        if (sum !== 16'sd0 || axon !== 16'sd0) begin
            errors++;
            $display("FAIL midrst_data got sum=%0d axon=%0d want 0/0", sum, axon);
        end
        rst_n = 1'b1;
        cyc();
        run_eval(0, '{4096, 2048, 0, 0}, '{2048, 2048, 0, 0}, s_o, a_o, lat);
        checks++;
        if (s_o != 3072 || a_o != 2816 || lat != 6) begin
            errors++;
            $display("FAIL midrst_fresh got %0d/%0d/%0d want 3072/2816/6",
                     s_o, a_o, lat);
        end
    endtask

    task automatic test_sigmoid();
        int codes[7] = '{4096, -4096, 9728, -9728, 20480, -20480, 0};
        int exp_y[7] = '{3072, 1024, 3760, 336, 4096, 0, 2048};
        for (int i = 0; i < 7; i++) begin
            sp_s = 16'(codes[i]);
            #1;
            checks++;
            if (int'(sp_y) != exp_y[i]) begin
                errors++;
                $display("FAIL plan_%0d got %0d want %0d", codes[i], sp_y, exp_y[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_saturate();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_sigmoid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
